// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit
//   Multi-cycle RV32M execute unit that sits beside the single-cycle ALU.
//   It executes MUL/MULH/MULHSU/MULHU with a fixed latency. It executes
//   DIV/DIVU/REM/REMU with an iterative restoring divider. Divide-by-zero and
//   signed overflow exit early with a one-cycle result.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   flush                kills any in-flight operation; a request in the same cycle is dropped
//   in_valid / in_ready  request handshake
//   function_3           RV32M funct3 (000 MUL .. 011 MULHU, 100 DIV .. 111 REMU)
//   rs1_data, rs2_data   operands (dividend/multiplicand, divisor/multiplier)
//   rd_addr              destination tag, returned with the result on out_rd
//   out_valid/out_ready  result handshake; out_data/out_rd are held while stalled
//   busy                 high whenever the unit is not idle
module exe_muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      function_3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int DIV_STEPS = XLEN / DIV_BITS;
  localparam int CNT_MAX   = (DIV_STEPS > MUL_LATENCY) ? DIV_STEPS : MUL_LATENCY;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ALL_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Two's-complement negation.
  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  // Full-width product of sign- or zero-extended operands, then pick low/high half.
  // f[1:0]: 00 MUL (low half), 01 MULH (s x s), 10 MULHSU (s x u), 11 MULHU (u x u).
  function automatic logic [XLEN-1:0] f_mul(input logic [1:0] f,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic              a_sgn;
    logic              b_sgn;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    a_sgn = (f != 2'b11) && a[XLEN-1];
    b_sgn = (f == 2'b01) && b[XLEN-1];
    a_ext = {{XLEN{a_sgn}}, a};
    b_ext = {{XLEN{b_sgn}}, b};
    prod  = a_ext * b_ext;
    return (f == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // DIV_BITS restoring steps. The dividend shifts out of the top of quo.
  // Quotient bits shift into the bottom of quo. Result is {remainder, quotient}.
  function automatic logic [2*XLEN-1:0] f_div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dvsr);
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] q;
    r = rem;
    q = quo;
    for (int i = 0; i < DIV_BITS; i++) begin
      shifted = {r, q[XLEN-1]};
      diff    = shifted - {1'b0, dvsr};
      q       = {q[XLEN-2:0], ~diff[XLEN]};
      r       = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    end
    return {r, q};
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [XLEN-1:0]   r_op_a;      // multiplicand, or dividend/quotient shift register
  logic [XLEN-1:0]   r_op_b;      // multiplier, or |divisor|
  logic [XLEN-1:0]   r_rem;       // partial remainder
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd_tag;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_out_data;
  logic [4:0]        r_out_rd;

  logic              w_accept;
  logic              w_signed_div;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [2*XLEN-1:0] w_first_step;
  logic [2*XLEN-1:0] w_next_step;
  logic [XLEN-1:0]   w_fix_q;
  logic [XLEN-1:0]   w_fix_r;
  logic              w_load_op;
  logic              w_load_out;
  logic              w_div_adv;
  logic [XLEN-1:0]   w_res;
  logic [4:0]        w_res_rd;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready && !flush;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;
  assign out_rd    = r_out_rd;

  // Operand conditioning for a divide presented on the inputs this cycle.
  // DIV (100) and REM (110) are the signed divide operations.
  assign w_signed_div = function_3[2] && !function_3[0];
  assign w_a_neg      = w_signed_div && rs1_data[XLEN-1];
  assign w_b_neg      = w_signed_div && rs2_data[XLEN-1];
  assign w_abs_a      = w_a_neg ? f_neg(rs1_data) : rs1_data;
  assign w_abs_b      = w_b_neg ? f_neg(rs2_data) : rs2_data;
  assign w_div_zero   = (rs2_data == ALL_ZERO);
  assign w_div_ovf    = w_signed_div && (rs1_data == INT_MIN) && (rs2_data == ALL_ONES);
  assign w_special    = w_div_zero || w_div_ovf;
  // function_3[1] selects the remainder. Divide-by-zero gives q = ~0, r = rs1.
  // Signed overflow gives q = rs1, r = 0.
  assign w_special_res = function_3[1] ? (w_div_zero ? rs1_data : ALL_ZERO)
                                       : (w_div_zero ? ALL_ONES : rs1_data);

  // The first quotient step runs in the accept cycle. The remaining steps, plus
  // the FIX cycle, then hit the advertised XLEN/DIV_BITS+1 latency.
  assign w_first_step = f_div_step(ALL_ZERO, w_abs_a, w_abs_b);
  assign w_next_step  = f_div_step(r_rem, r_op_a, r_op_b);

  assign w_fix_q = r_neg_q ? f_neg(r_op_a) : r_op_a;
  assign w_fix_r = r_neg_r ? f_neg(r_rem) : r_rem;

  // Next-state, counter and result-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_op   = 1'b0;
    w_load_out  = 1'b0;
    w_div_adv   = 1'b0;
    w_res       = r_out_data;
    w_res_rd    = r_rd_tag;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            w_load_op = 1'b1;
            if (!function_3[2]) begin
              if (MUL_LATENCY == 1) begin
                w_state_nxt = S_DONE;
                w_cnt_nxt   = CNT_ZERO;
                w_load_out  = 1'b1;
                w_res       = f_mul(function_3[1:0], rs1_data, rs2_data);
                w_res_rd    = rd_addr;
              end else begin
                w_state_nxt = S_MUL;
                w_cnt_nxt   = CNT_MUL;
              end
            end else if (w_special) begin
              w_state_nxt = S_DONE;
              w_cnt_nxt   = CNT_ZERO;
              w_load_out  = 1'b1;
              w_res       = w_special_res;
              w_res_rd    = rd_addr;
            end else begin
              w_state_nxt = (DIV_STEPS == 1) ? S_FIX : S_DIV;
              w_cnt_nxt   = CNT_DIV;
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_MUL: begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = S_DONE;
            w_load_out  = 1'b1;
            w_res       = f_mul(r_funct3[1:0], r_op_a, r_op_b);
          end else begin
            w_state_nxt = S_MUL;
          end
        end
        S_DIV: begin
          w_div_adv = 1'b1;
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = S_FIX;
          end else begin
            w_state_nxt = S_DIV;
          end
        end
        S_FIX: begin
          w_state_nxt = S_DONE;
          w_load_out  = 1'b1;
          w_res       = r_funct3[1] ? w_fix_r : w_fix_q;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Operand capture at accept and divider iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a   <= ALL_ZERO;
      r_op_b   <= ALL_ZERO;
      r_rem    <= ALL_ZERO;
      r_funct3 <= 3'b000;
      r_rd_tag <= 5'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_load_op) begin
      r_funct3 <= function_3;
      r_rd_tag <= rd_addr;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      if (function_3[2]) begin
        r_rem  <= w_first_step[2*XLEN-1:XLEN];
        r_op_a <= w_first_step[XLEN-1:0];
        r_op_b <= w_abs_b;
      end else begin
        r_rem  <= ALL_ZERO;
        r_op_a <= rs1_data;
        r_op_b <= rs2_data;
      end
    end else if (w_div_adv) begin
      r_rem  <= w_next_step[2*XLEN-1:XLEN];
      r_op_a <= w_next_step[XLEN-1:0];
    end else begin
      r_rem  <= r_rem;
      r_op_a <= r_op_a;
    end
  end

  // Result registers, written only when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= ALL_ZERO;
      r_out_rd   <= 5'd0;
    end else if (w_load_out) begin
      r_out_data <= w_res;
      r_out_rd   <= w_res_rd;
    end else begin
      r_out_data <= r_out_data;
      r_out_rd   <= r_out_rd;
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit with default parameters.
// The reference model works at the transaction level. It computes each result
// with plain arithmetic and counts down the architectural latency. Directed
// operations then pin both the DUT and the model to hand-computed values.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  function_3 = 3'b000;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic [4:0]  rd_addr = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  exe_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .function_3(function_3), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // RV32M result from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic [31:0] res;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
    ia = $signed(a); ib = $signed(b);
    res = 32'h0;
    case (f)
      3'b000: begin p = sa * sb; res = p[31:0]; end
      3'b001: begin p = sa * sb; res = p[63:32]; end
      3'b010: begin p = sa * ub; res = p[63:32]; end
      3'b011: begin p = ua * ub; res = p[63:32]; end
      3'b100: res = (b == 0) ? 32'hFFFF_FFFF :
                    (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
      3'b101: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: res = (b == 0) ? a :
                    (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
      default: res = (b == 0) ? a : a % b;
    endcase
    return res;
  endfunction

  // Cycles from the accept edge to the first out_valid cycle, with the accept cycle counted as 1.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Transaction-level model: one op in flight, a countdown to valid, and a held result.
  logic        m_busy, m_valid, m_ready;
  int          m_wait;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  assign m_ready = !m_busy || (m_valid && out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_wait <= 0; m_data <= 32'h0; m_rd <= 5'd0;
    end else if (flush) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end else if (in_valid && m_ready) begin
      m_busy  <= 1'b1;
      m_data  <= ref_result(function_3, rs1_data, rs2_data);
      m_rd    <= rd_addr;
      m_wait  <= ref_latency(function_3, rs1_data, rs2_data) - 1;
      m_valid <= (ref_latency(function_3, rs1_data, rs2_data) == 1);
    end else if (m_valid && out_ready) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end else if (m_busy && !m_valid) begin
      m_wait  <= m_wait - 1;
      m_valid <= (m_wait == 1);
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("in_ready", in_ready, m_ready);
      check("out_valid", out_valid, m_valid);
      check("busy", busy, m_busy);
      if (m_valid) begin
        check("out_data", out_data, m_data);
        check("out_rd", out_rd, m_rd);
      end
    end
  end

  // Issue one op, then wait a bounded time for out_valid and check latency and literal result.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_d, input int exp_lat);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; function_3 = f; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check({nm, "_data"}, out_data, exp_d);
    check({nm, "_rd"}, {27'h0, out_rd}, {27'h0, rd});
  endtask

  initial begin
    int seen;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_rd", out_rd, 5'd0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #3 rst_n = 1'b1;
    chk_en = 1'b1;

    out_ready = 1'b1;
    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 2);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 2);
    run_op("mulh1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 2);
    run_op("mulh2",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 2);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFD, 33);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        5'd7,  32'hFFFF_FFFF, 33);
    run_op("divu",   3'b101, 32'd100,      32'd7,        5'd8,  32'd14,        33);
    run_op("remu",   3'b111, 32'd100,      32'd7,        5'd9,  32'd2,         33);
    run_op("div_nd", 3'b100, 32'd7,        32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33);
    run_op("rem_nd", 3'b110, 32'd7,        32'hFFFF_FFFE, 5'd11, 32'd1,         33);
    run_op("div0",   3'b100, 32'd5,        32'd0,        5'd12, 32'hFFFF_FFFF, 1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        5'd13, 32'd5,         1);
    run_op("divu0",  3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFF_FFFF, 1);
    run_op("remu0",  3'b111, 32'd5,        32'd0,        5'd15, 32'd5,         1);
    run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0,         1);
    run_op("divu_b", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0,         33);

    // Flush in the 10th DIV cycle, with a competing request that must be dropped.
    @(posedge clk); #1;
    in_valid = 1'b1; function_3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; function_3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_busy", busy, 1'b0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", 32'(seen), 32'd0);

    // Back-pressure: hold the result for 5 cycles, then pulse out_ready with a new MUL.
    out_ready = 1'b0;
    run_op("bp_mul", 3'b000, 32'd3, 32'd5, 5'd9, 32'd15, 2);
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, 32'd15);
      check("hold_rd", {27'h0, out_rd}, 32'd9);
    end
    in_valid = 1'b1; function_3 = 3'b000; rs1_data = 32'd6; rs2_data = 32'd7; rd_addr = 5'd10;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_busy", busy, 1'b1);
    check("b2b_mid_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("b2b_valid", out_valid, 1'b1);
    check("b2b_data", out_data, 32'd42);
    check("b2b_rd", {27'h0, out_rd}, 32'd10);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a divide.
    in_valid = 1'b1; function_3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_out_rd", {27'h0, out_rd}, 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    chk_en = 1'b1;
    run_op("post_rst", 3'b101, 32'd100, 32'd7, 5'd21, 32'd14, 33);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
